// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for the execute-stage branch resolve unit:
// condition encodings, FSM states and instruction size.
package branch_resolve_unit_pkg;

   typedef enum logic [2:0] {
      BEQ    = 3'b000,
      BNE    = 3'b001,
      BR_NOP = 3'b010,
      BLT    = 3'b100,
      BGE    = 3'b101,
      BLTU   = 3'b110,
      BGEU   = 3'b111
   } br_ctrl_e;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      EVAL     = 2'd1,
      REDIRECT = 2'd2
   } br_state_t;

   localparam int INSTR_BYTES = 4;

   // True only for real conditional codes; NOP and 3'b011 are not branches
   function automatic logic is_cond(input logic [2:0] c);
      return (c == BEQ) || (c == BNE) || (c == BLT) ||
             (c == BGE) || (c == BLTU) || (c == BGEU);
   endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Branch-in / redirect-out bundle between decode, execute and fetch,
// plus the resolve status and performance counters.
interface branch_resolve_unit_if #(
   parameter int XLEN  = 32,
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
);
   logic             br_valid;
   logic             br_ready;
   logic [2:0]       branch_control;
   logic [XLEN-1:0]  rs1_val;
   logic [XLEN-1:0]  rs2_val;
   logic [12:0]      imm;
   logic [PC_W-1:0]  pc;
   logic             pred_taken;
   logic             flush;
   logic             redir_valid;
   logic             redir_ready;
   logic [PC_W-1:0]  redir_pc;
   logic             resolved_valid;
   logic             resolved_taken;
   logic             br_misaligned;
   logic [CNT_W-1:0] br_count;
   logic [CNT_W-1:0] mispredict_count;

   modport master (
      output br_valid, branch_control, rs1_val, rs2_val,
      output imm, pc, pred_taken, flush, redir_ready,
      input  br_ready, redir_valid, redir_pc,
      input  resolved_valid, resolved_taken, br_misaligned,
      input  br_count, mispredict_count
   );

   modport slave (
      input  br_valid, branch_control, rs1_val, rs2_val,
      input  imm, pc, pred_taken, flush, redir_ready,
      output br_ready, redir_valid, redir_pc,
      output resolved_valid, resolved_taken, br_misaligned,
      output br_count, mispredict_count
   );
endinterface

// File: rtl/branch_resolve_unit_compare.sv
// Combinational B-type condition evaluation.
// Unknown codes and BR_NOP resolve as not taken.
module branch_compare
   import branch_resolve_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      branch_control,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   output logic            taken
);
   logic eq;
   logic lt;
   logic ltu;

   assign eq  = (rs1_val == rs2_val);
   assign lt  = ($signed(rs1_val) < $signed(rs2_val));
   assign ltu = (rs1_val < rs2_val);

   always_comb begin
      taken = 1'b0;
      unique case (1'b1)
         (branch_control == BEQ):  taken = eq;
         (branch_control == BNE):  taken = !eq;
         (branch_control == BLT):  taken = lt;
         (branch_control == BGE):  taken = !lt;
         (branch_control == BLTU): taken = ltu;
         (branch_control == BGEU): taken = !ltu;
         default:                  taken = 1'b0;
      endcase
   end
endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: condition, target, mispredict
// redirect to fetch over valid/ready, saturating perf counters.
module branch_resolve_unit
   import branch_resolve_unit_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int PC_W  = 32,
   parameter int CNT_W = 32
) (
   input logic                 clk,
   input logic                 rst_n,
   branch_resolve_unit_if.slave bus
);
   br_state_t        state_q, state_d;
   logic [2:0]       ctrl_q, ctrl_d;
   logic [XLEN-1:0]  rs1_q, rs1_d;
   logic [XLEN-1:0]  rs2_q, rs2_d;
   logic [12:0]      imm_q, imm_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic             pred_q, pred_d;
   logic             res_valid_q, res_valid_d;
   logic             res_taken_q, res_taken_d;
   logic             misal_q, misal_d;
   logic             redir_valid_q, redir_valid_d;
   logic [PC_W-1:0]  redir_pc_q, redir_pc_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;

   logic             taken;
   logic [PC_W-1:0]  target;
   logic [PC_W-1:0]  fallthru;

   branch_compare #(.XLEN(XLEN)) u_cmp (
      .branch_control (ctrl_q),
      .rs1_val        (rs1_q),
      .rs2_val        (rs2_q),
      .taken          (taken)
   );

   // Both adders wrap modulo 2^PC_W
   assign target   = pc_q + {{(PC_W-13){imm_q[12]}}, imm_q};
   assign fallthru = pc_q + PC_W'(INSTR_BYTES);

   always_comb begin
      state_d       = state_q;
      ctrl_d        = ctrl_q;
      rs1_d         = rs1_q;
      rs2_d         = rs2_q;
      imm_d         = imm_q;
      pc_d          = pc_q;
      pred_d        = pred_q;
      res_valid_d   = 1'b0;
      res_taken_d   = 1'b0;
      misal_d       = 1'b0;
      redir_valid_d = redir_valid_q;
      redir_pc_d    = redir_pc_q;
      br_cnt_d      = br_cnt_q;
      mis_cnt_d     = mis_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.br_valid && !bus.flush) begin
               ctrl_d  = bus.branch_control;
               rs1_d   = bus.rs1_val;
               rs2_d   = bus.rs2_val;
               imm_d   = bus.imm;
               pc_d    = bus.pc;
               pred_d  = bus.pred_taken;
               state_d = EVAL;
            end
         end
         EVAL: begin
            state_d = IDLE;
            if (!bus.flush) begin
               res_valid_d = 1'b1;
               res_taken_d = taken;
               if (is_cond(ctrl_q) && !(&br_cnt_q))
                  br_cnt_d = br_cnt_q + CNT_W'(1);
               if (taken && (target[1:0] != 2'b00)) begin
                  misal_d = 1'b1;
               end else if (taken != pred_q) begin
                  redir_valid_d = 1'b1;
                  redir_pc_d    = taken ? target : fallthru;
                  if (!(&mis_cnt_q))
                     mis_cnt_d = mis_cnt_q + CNT_W'(1);
                  state_d = REDIRECT;
               end
            end
         end
         REDIRECT: begin
            if (bus.redir_ready || bus.flush) begin
               redir_valid_d = 1'b0;
               state_d       = IDLE;
            end
         end
         default: begin
            redir_valid_d = 1'b0;
            state_d       = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ctrl_q        <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         imm_q         <= '0;
         pc_q          <= '0;
         pred_q        <= 1'b0;
         res_valid_q   <= 1'b0;
         res_taken_q   <= 1'b0;
         misal_q       <= 1'b0;
         redir_valid_q <= 1'b0;
         redir_pc_q    <= '0;
         br_cnt_q      <= '0;
         mis_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         ctrl_q        <= ctrl_d;
         rs1_q         <= rs1_d;
         rs2_q         <= rs2_d;
         imm_q         <= imm_d;
         pc_q          <= pc_d;
         pred_q        <= pred_d;
         res_valid_q   <= res_valid_d;
         res_taken_q   <= res_taken_d;
         misal_q       <= misal_d;
         redir_valid_q <= redir_valid_d;
         redir_pc_q    <= redir_pc_d;
         br_cnt_q      <= br_cnt_d;
         mis_cnt_q     <= mis_cnt_d;
      end
   end

   assign bus.br_ready         = (state_q == IDLE);
   assign bus.redir_valid      = redir_valid_q;
   assign bus.redir_pc         = redir_pc_q;
   assign bus.resolved_valid   = res_valid_q;
   assign bus.resolved_taken   = res_taken_q;
   assign bus.br_misaligned    = misal_q;
   assign bus.br_count         = br_cnt_q;
   assign bus.mispredict_count = mis_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; a second copy with 2-bit
// counters sees the same stimulus to exercise counter saturation.
module tb_branch_resolve_unit;
   import branch_resolve_unit_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   branch_resolve_unit_if #(.XLEN(32), .PC_W(32), .CNT_W(32)) bus ();
   branch_resolve_unit_if #(.XLEN(32), .PC_W(32), .CNT_W(2))  bus2 ();

   branch_resolve_unit #(.XLEN(32), .PC_W(32), .CNT_W(32)) dut (
      .clk (clk), .rst_n (rst_n), .bus (bus)
   );

   branch_resolve_unit #(.XLEN(32), .PC_W(32), .CNT_W(2)) dut2 (
      .clk (clk), .rst_n (rst_n), .bus (bus2)
   );

   assign bus2.br_valid       = bus.br_valid;
   assign bus2.branch_control = bus.branch_control;
   assign bus2.rs1_val        = bus.rs1_val;
   assign bus2.rs2_val        = bus.rs2_val;
   assign bus2.imm            = bus.imm;
   assign bus2.pc             = bus.pc;
   assign bus2.pred_taken     = bus.pred_taken;
   assign bus2.flush          = bus.flush;
   assign bus2.redir_ready    = bus.redir_ready;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Present one branch in an IDLE cycle; returns in the EVAL cycle
   task automatic send(input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [12:0] im,
                       input logic [31:0] p, input logic pr);
      bus.br_valid       = 1'b1;
      bus.branch_control = c;
      bus.rs1_val        = a;
      bus.rs2_val        = b;
      bus.imm            = im;
      bus.pc             = p;
      bus.pred_taken     = pr;
      step();
      bus.br_valid = 1'b0;
   endtask

   initial begin
      bus.br_valid       = 1'b0;
      bus.branch_control = 3'b000;
      bus.rs1_val        = '0;
      bus.rs2_val        = '0;
      bus.imm            = '0;
      bus.pc             = '0;
      bus.pred_taken     = 1'b0;
      bus.flush          = 1'b0;
      bus.redir_ready    = 1'b1;

      step();
      chk("rst_br_ready", bus.br_ready, 1);
      chk("rst_redir_valid", bus.redir_valid, 0);
      chk("rst_resolved", bus.resolved_valid, 0);
      chk("rst_br_count", bus.br_count, 0);
      chk("rst_mis_count", bus.mispredict_count, 0);
      rst_n = 1'b1;
      step();

      // BEQ taken, predicted not taken
      send(BEQ, 32'd5, 32'd5, 13'h010, 32'h100, 1'b0);
      chk("beq_n1_resolved", bus.resolved_valid, 0);
      chk("beq_n1_br_ready", bus.br_ready, 0);
      step();
      chk("beq_resolved", bus.resolved_valid, 1);
      chk("beq_taken", bus.resolved_taken, 1);
      chk("beq_redir_valid", bus.redir_valid, 1);
      chk("beq_redir_pc", bus.redir_pc, 32'h110);
      chk("beq_mis", bus.mispredict_count, 1);
      chk("beq_br", bus.br_count, 1);
      step();
      chk("beq_redir_done", bus.redir_valid, 0);
      chk("beq_ready_back", bus.br_ready, 1);
      chk("beq_pulse_end", bus.resolved_valid, 0);

      // Signed vs unsigned less-than
      send(BLT, 32'hFFFF_FFFF, 32'd1, 13'h020, 32'h200, 1'b1);
      step();
      chk("blt_taken", bus.resolved_taken, 1);
      chk("blt_no_redir", bus.redir_valid, 0);
      chk("blt_br_ready", bus.br_ready, 1);
      send(BLTU, 32'hFFFF_FFFF, 32'd1, 13'h020, 32'h200, 1'b1);
      step();
      chk("bltu_taken", bus.resolved_taken, 0);
      chk("bltu_redir", bus.redir_valid, 1);
      chk("bltu_redir_pc", bus.redir_pc, 32'h204);
      chk("bltu_br", bus.br_count, 3);
      chk("bltu_mis", bus.mispredict_count, 2);
      step();

      // Negative offset and address wrap
      send(BNE, 32'd1, 32'd2, 13'h1FF0, 32'h8, 1'b0);
      step();
      chk("neg_redir_pc", bus.redir_pc, 32'hFFFF_FFF8);
      step();
      send(BEQ, 32'd1, 32'd2, 13'h010, 32'hFFFF_FFFC, 1'b1);
      step();
      chk("wrap_redir", bus.redir_valid, 1);
      chk("wrap_redir_pc", bus.redir_pc, 32'h0);
      chk("wrap_mis", bus.mispredict_count, 4);
      step();

      // Redirect backpressure for 5 cycles
      bus.redir_ready = 1'b0;
      send(BNE, 32'd1, 32'd2, 13'h040, 32'h300, 1'b0);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("bp_redir_valid", bus.redir_valid, 1);
         chk("bp_redir_pc", bus.redir_pc, 32'h340);
         chk("bp_br_ready", bus.br_ready, 0);
         if (i < 4) step();
      end
      bus.redir_ready = 1'b1;
      step();
      chk("bp_ready_after", bus.br_ready, 1);
      chk("bp_redir_drop", bus.redir_valid, 0);
      chk("bp_mis", bus.mispredict_count, 5);

      // Flush during EVAL
      send(BEQ, 32'd5, 32'd5, 13'h010, 32'h400, 1'b0);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("fe_resolved", bus.resolved_valid, 0);
      chk("fe_redir", bus.redir_valid, 0);
      chk("fe_br", bus.br_count, 6);
      chk("fe_mis", bus.mispredict_count, 5);
      chk("fe_br_ready", bus.br_ready, 1);

      // Flush during REDIRECT
      bus.redir_ready = 1'b0;
      send(BEQ, 32'd5, 32'd5, 13'h010, 32'h500, 1'b0);
      step();
      chk("fr_redir", bus.redir_valid, 1);
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      chk("fr_redir_drop", bus.redir_valid, 0);
      chk("fr_br_ready", bus.br_ready, 1);
      chk("fr_mis", bus.mispredict_count, 6);
      send(BGE, 32'd3, 32'd3, 13'h008, 32'h600, 1'b1);
      step();
      chk("fr_next_resolved", bus.resolved_valid, 1);
      chk("fr_next_taken", bus.resolved_taken, 1);
      chk("fr_next_redir", bus.redir_valid, 0);
      chk("fr_next_br", bus.br_count, 8);
      bus.redir_ready = 1'b1;

      // BR_NOP predicted taken: redirect to fallthrough, no br count
      send(BR_NOP, 32'd0, 32'd0, 13'h040, 32'h700, 1'b1);
      step();
      chk("nop_resolved", bus.resolved_valid, 1);
      chk("nop_taken", bus.resolved_taken, 0);
      chk("nop_redir_pc", bus.redir_pc, 32'h704);
      chk("nop_br", bus.br_count, 8);
      chk("nop_mis", bus.mispredict_count, 7);
      step();
      send(3'b011, 32'd0, 32'd0, 13'h040, 32'h780, 1'b0);
      step();
      chk("undef_resolved", bus.resolved_valid, 1);
      chk("undef_br", bus.br_count, 8);

      // Taken to a misaligned target
      send(BEQ, 32'd5, 32'd5, 13'h002, 32'h800, 1'b0);
      step();
      chk("mis_pulse", bus.br_misaligned, 1);
      chk("mis_no_redir", bus.redir_valid, 0);
      chk("mis_mis", bus.mispredict_count, 7);
      chk("mis_br", bus.br_count, 9);
      step();
      chk("mis_pulse_end", bus.br_misaligned, 0);

      // BGEU vs BGE with rs2 = -1
      send(BGEU, 32'd1, 32'hFFFF_FFFF, 13'h100, 32'h900, 1'b0);
      step();
      chk("bgeu_taken", bus.resolved_taken, 0);
      chk("bgeu_redir", bus.redir_valid, 0);
      send(BGE, 32'd1, 32'hFFFF_FFFF, 13'h100, 32'h900, 1'b0);
      step();
      chk("bge_taken", bus.resolved_taken, 1);
      chk("bge_redir_pc", bus.redir_pc, 32'hA00);
      chk("bge_br", bus.br_count, 11);
      chk("bge_mis", bus.mispredict_count, 8);
      step();

      // 2-bit counters saturate at all-ones
      chk("sat_br", bus2.br_count, 3);
      chk("sat_mis", bus2.mispredict_count, 3);

      // Async reset while a redirect is pending
      bus.redir_ready = 1'b0;
      send(BNE, 32'd1, 32'd2, 13'h010, 32'hA00, 1'b0);
      step();
      chk("ar_pre_redir", bus.redir_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_redir_valid", bus.redir_valid, 0);
      chk("ar_redir_pc", bus.redir_pc, 0);
      chk("ar_br_ready", bus.br_ready, 1);
      chk("ar_br", bus.br_count, 0);
      chk("ar_mis", bus.mispredict_count, 0);
      #2 rst_n = 1'b1;
      bus.redir_ready = 1'b1;
      step();
      chk("ar_post_redir", bus.redir_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage consumer of decoded B-type branches: rs1/rs2 register values, 13-bit byte offset, 3-bit branch_control.
- Evaluates the branch condition and computes the taken target.
- Compares the outcome with the fetch-stage static prediction and issues a PC redirect to fetch on a mispredict, using a valid/ready handshake.
- Keeps saturating branch and mispredict counters for performance monitoring.

Parameters:
- XLEN, 32, width of rs1/rs2 operand values
- PC_W, 32, program counter width
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- br_valid  in  1  decoded branch presented
- br_ready  out  1  unit can accept a branch
- branch_control  in  3  condition code; encodings BEQ/BNE/BLT/BGE/BLTU/BGEU/BR_NOP from processor_defines.sv
- rs1_val  in  XLEN  rs1 operand
- rs2_val  in  XLEN  rs2 operand
- imm  in  13  signed byte offset, bit 0 always 0
- pc  in  PC_W  address of the branch instruction
- pred_taken  in  1  fetch prediction for this branch
- flush  in  1  pipeline flush from an older instruction
- redir_valid  out  1  redirect request to fetch
- redir_ready  in  1  fetch accepts redirect
- redir_pc  out  PC_W  corrected fetch address
- resolved_valid  out  1  one-cycle pulse: branch resolved
- resolved_taken  out  1  outcome, valid with resolved_valid
- br_misaligned  out  1  one-cycle pulse: taken target not 4-byte aligned
- br_count  out  CNT_W  resolved non-NOP branches
- mispredict_count  out  CNT_W  redirects issued

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE.
  - All outputs 0 except br_ready=1.
  - Counters 0, capture registers 0.
- FSM states: IDLE, EVAL, REDIRECT.
- IDLE:
  - br_ready=1.
  - br_valid=1 latches branch_control, rs1_val, rs2_val, imm, pc, pred_taken; next state EVAL.
- EVAL:
  - br_ready=0. Operands come only from the capture registers.
  - Conditions:
    - BEQ: eq.
    - BNE: !eq.
    - BLT/BGE: signed compare.
    - BLTU/BGEU: unsigned compare.
    - BR_NOP or any undefined code: not taken.
  - Target = pc + sign_extend(imm), truncated modulo 2^PC_W (wrap allowed). Fallthrough = pc + 4, also modulo.
  - Registered into the following cycle:
    - resolved_valid=1.
    - resolved_taken.
    - br_count+1 if the code is not BR_NOP/undefined.
  - If taken and target[1:0]!=0:
    - br_misaligned=1.
    - No redirect, no mispredict count.
    - Next state IDLE.
  - Else if taken != pred_taken:
    - redir_pc = taken ? target : fallthrough.
    - redir_valid=1, mispredict_count+1.
    - Next state REDIRECT.
  - Else next state IDLE.
- Latency: handshake in cycle N; resolved_valid, resolved_taken and redir_valid appear in cycle N+2. Peak throughput is one branch per 2 cycles.
- REDIRECT:
  - redir_valid and redir_pc held stable until redir_ready=1.
  - Handshake cycle is the last cycle with redir_valid=1; next state IDLE (br_ready=1 the following cycle).
- Counters saturate at all-ones and never wrap.
- flush has the highest priority, in any state:
  - Next state IDLE.
  - In EVAL: suppresses resolved_valid, br_misaligned, the redirect and both counter updates for that branch.
  - In REDIRECT: drops redir_valid next cycle; mispredict_count is not decremented.
  - In IDLE: blocks acceptance that cycle (br_ready still 1, but no capture).
- flush and redir_ready in the same cycle: treat as handshake completed; next state IDLE.
- Reset mid-operation: immediate return to reset values; any pending redirect is lost.

Decomposition:
- Shared package (processor_defines.sv): branch_control encodings; FSM state enum br_state_t {IDLE, EVAL, REDIRECT}; constant INSTR_BYTES=4.
- One sub-module, branch_compare: combinational condition evaluation. Inputs: branch_control, rs1_val, rs2_val. Output: taken.
- Top module holds the FSM, capture registers, target adders and counters.

Test Plan:
- BEQ: rs1=5, rs2=5, pc=0x100, imm=0x010, pred_taken=0.
  - resolved_taken=1 at N+2.
  - redir_valid=1 with redir_pc=0x110; mispredict_count=1, br_count=1.
- BLT signed vs BLTU: rs1=0xFFFFFFFF, rs2=1, pred_taken=1.
  - BLT: taken, no redirect.
  - BLTU: not taken; redir_pc=pc+4.
- Negative offset and wrap:
  - pc=0x8, imm=0x1FF0 (−16), BNE with rs1!=rs2, pred_taken=0 → redir_pc=0xFFFFFFF8.
  - pc=0xFFFFFFFC, not taken, pred_taken=1 → redir_pc=0x0.
- Backpressure: redir_ready low for 5 cycles.
  - redir_valid and redir_pc stable throughout; br_ready=0 throughout.
  - br_ready=1 the cycle after redir_ready rises.
- Flush in EVAL and in REDIRECT.
  - EVAL: no resolved_valid; counters unchanged.
  - REDIRECT: redir_valid drops next cycle; next branch accepted normally.
- Edge codes and counters:
  - BR_NOP with pred_taken=1 → redirect to pc+4; br_count unchanged.
  - Taken BEQ with imm=0x002 → br_misaligned pulse, no redirect.
  - Preloaded br_count=0xFFFFFFFF stays saturated.
  - rst_n low during REDIRECT → all outputs reset asynchronously.
